// File: rtl/wb_regfile.sv
// Writeback stage: selects/format writeback data and commits it into the
// integer register file; provides two async read ports with optional bypass.
module wb_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_wb_reg_write,
  input  logic            mem_wb_mem_to_reg,
  input  logic [XLEN-1:0] mem_wb_mem_data,
  input  logic [XLEN-1:0] mem_wb_alu_o,
  input  logic [2:0]      mem_wb_funct3,
  input  logic [4:0]      mem_wb_rd_idx,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_en
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_byte = mem_wb_mem_data[{mem_wb_alu_o[1:0], 3'b000} +: 8];
    ld_half = mem_wb_alu_o[1] ? mem_wb_mem_data[31:16] : mem_wb_mem_data[15:0];
    // Reserved encodings (011, 110, 111) fall through to a full-word load.
    case (funct3_e'(mem_wb_funct3))
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_wb_mem_data;
    endcase
  end

  always_comb begin
    wb_data = mem_wb_mem_to_reg ? ld_data : mem_wb_alu_o;
    wb_en   = mem_wb_reg_write && (mem_wb_rd_idx != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (32'(mem_wb_rd_idx) < NREG)) begin
      regs_d[mem_wb_rd_idx[IW-1:0]] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_idx != '0) begin
      if (BYPASS && wb_en && (rs1_idx == mem_wb_rd_idx)) begin
        rs1_data = wb_data;
      end else if (32'(rs1_idx) < NREG) begin
        rs1_data = regs_q[rs1_idx[IW-1:0]];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_idx != '0) begin
      if (BYPASS && wb_en && (rs2_idx == mem_wb_rd_idx)) begin
        rs2_data = wb_data;
      end else if (32'(rs2_idx) < NREG) begin
        rs2_data = regs_q[rs2_idx[IW-1:0]];
      end
    end
  end

endmodule
